pipe_if_id: RTL and testbench
=============================

Name: pipe_if_id

Overview:
- Holds the architectural PC and the IF/ID pipeline latch.
- Directly downstream of stage_if: consumes its pc_next, pc4 and instr, and feeds pc back to it.
- Presents the latched instruction and pc4 to the ID stage.
- Applies stall and flush, inserts bubbles, detects the halt instruction, and keeps fetch and bubble performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word used for a bubble.
- HALT_INSTR, 32'h0000_000C, instruction word (syscall) that halts fetch.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_next  in  32  next PC selected by stage_if.
- pc4_in  in  32  pc+4 from stage_if.
- instr_in  in  32  fetched instruction from stage_if.
- stall  in  1  load-use hazard from ID: hold PC and the latch.
- flush  in  1  taken branch/jump/jr resolved downstream: squash the latch.
- pc  out  32  current PC, to stage_if.
- pc4_out  out  32  latched pc+4, to ID.
- instr_out  out  32  latched instruction, to ID.
- valid_out  out  1  instr_out is a real instruction.
- halted  out  1  fetch has stopped on HALT_INSTR.
- fetch_cnt  out  CNT_W  valid instructions latched.
- bubble_cnt  out  CNT_W  bubble/hold cycles in RUN.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: pc=RESET_PC, pc4_out=0, instr_out=NOP_INSTR, valid_out=0, halted=0, fetch_cnt=0, bubble_cnt=0, state=BOOT. All outputs are registered.
- States: BOOT, RUN, HALT. No other transitions exist.
- BOOT (exactly one cycle after reset release): pc holds RESET_PC, the latch loads a bubble, counters hold. Next state is RUN unconditionally; stall and flush are ignored.
- RUN priority order: flush > halt detect > stall > normal.
- RUN, flush=1 (any stall):
  - pc<=pc_next, instr_out<=NOP_INSTR, pc4_out<=0, valid_out<=0.
  - bubble_cnt increments.
  - Halt detection is suppressed, because the halt is on the wrong path.
- RUN, valid_out=1 and instr_out==HALT_INSTR, no flush:
  - Next state is HALT and halted<=1.
  - pc holds, the latch loads a bubble.
  - stall is ignored.
  - Neither counter changes.
- RUN, stall=1, no flush, no halt: pc, pc4_out, instr_out and valid_out all hold. bubble_cnt increments.
- RUN, normal (no stall, no flush, no halt):
  - pc<=pc_next, instr_out<=instr_in, pc4_out<=pc4_in, valid_out<=1.
  - fetch_cnt increments.
  - Latency: the instruction at PC p is visible on instr_out one cycle after pc=p.
- HALT: pc frozen, latch holds the bubble, counters frozen, stall and flush ignored. Exit is by reset only.
- Counters saturate at all-ones; they never wrap.
- Reset asserted mid-operation (any state, any cycle): all registers return to reset values immediately. No partial update is permitted.
- No combinational path from any input to any output.

Decomposition:
- Shared package cpu_pkg holds:
  - state encoding (BOOT, RUN, HALT, 2 bits);
  - NOP_INSTR and HALT_INSTR constants;
  - RESET_PC default.
- One sub-module is natural: sat_counter (CNT_W-bit saturating incrementer with enable and async active-low reset), instantiated twice.

Test Plan:
- Reset then release; pc_next=pc+4 loop, instr_in=32'h2001_0005 -> cycle 1: pc=0, valid_out=0 (BOOT). Cycle 2: pc=4, instr_out=32'h2001_0005, valid_out=1, fetch_cnt=1.
- In RUN at pc=8, hold stall=1 for 3 cycles -> pc=8, instr_out and pc4_out unchanged for 3 cycles. bubble_cnt=3, fetch_cnt unchanged.
- stall=1 and flush=1 together with pc_next=32'h0000_0040 -> next cycle pc=0x40, valid_out=0, instr_out=0, bubble_cnt+1.
- Latch 32'h0000_000C with no flush -> next cycle halted=1, valid_out=0, pc frozen. Flush pulse afterwards has no effect.
- Latch 32'h0000_000C with flush=1 in the same cycle -> halted stays 0, pc=pc_next, valid_out=0.
- CNT_W=4: run 20 normal cycles -> fetch_cnt stays 4'hF. Assert rst_n=0 mid-cycle -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end: IF/ID state encoding,
// bubble and halt instruction words, and the default reset PC.
package cpu_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   localparam logic [31:0] RESET_PC_C   = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR_C  = 32'h0000_0000;
   localparam logic [31:0] HALT_INSTR_C = 32'h0000_000C;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments when en is high and sticks at all-ones.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_if_id.sv
// Architectural PC and IF/ID pipeline latch with stall, flush, bubble
// insertion, halt detection and fetch/bubble performance counters.
module pipe_if_id
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_C,
   parameter logic [31:0] NOP_INSTR  = NOP_INSTR_C,
   parameter logic [31:0] HALT_INSTR = HALT_INSTR_C,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      pc_next,
   input  logic [31:0]      pc4_in,
   input  logic [31:0]      instr_in,
   input  logic             stall,
   input  logic             flush,
   output logic [31:0]      pc,
   output logic [31:0]      pc4_out,
   output logic [31:0]      instr_out,
   output logic             valid_out,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;
   logic        halted_q, halted_d;
   logic        fetch_inc;
   logic        bubble_inc;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc4_d      = pc4_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      halted_d   = halted_q;
      fetch_inc  = 1'b0;
      bubble_inc = 1'b0;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            instr_d = NOP_INSTR;
            pc4_d   = '0;
            valid_d = 1'b0;
         end
         ST_RUN: begin
            if (flush) begin
               // A halt sitting in the latch is on the wrong path, so flush wins.
               pc_d       = pc_next;
               instr_d    = NOP_INSTR;
               pc4_d      = '0;
               valid_d    = 1'b0;
               bubble_inc = 1'b1;
            end else if (valid_q && (instr_q == HALT_INSTR)) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
               instr_d  = NOP_INSTR;
               pc4_d    = '0;
               valid_d  = 1'b0;
            end else if (stall) begin
               bubble_inc = 1'b1;
            end else begin
               pc_d      = pc_next;
               instr_d   = instr_in;
               pc4_d     = pc4_in;
               valid_d   = 1'b1;
               fetch_inc = 1'b1;
            end
         end
         ST_HALT: begin
         end
         default: begin
            state_d = ST_HALT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         pc4_q    <= '0;
         instr_q  <= NOP_INSTR;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc4_q    <= pc4_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_fetch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (fetch_inc),
      .cnt   (fetch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bubble_inc),
      .cnt   (bubble_cnt)
   );

   assign pc        = pc_q;
   assign pc4_out   = pc4_q;
   assign instr_out = instr_q;
   assign valid_out = valid_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_pipe_if_id.sv
// Bench for pipe_if_id: directed plus random stall/flush traffic compared each
// cycle against a rule-level model, on a 16-bit and a 4-bit counter instance.
module tb_pipe_if_id;

   localparam logic [31:0] HALT_W = 32'h0000_000C;
   localparam logic [31:0] NOP_W  = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc_next, pc4_in, instr_in;
   logic        stall, flush;

   logic [31:0] pc_a, pc4_a, instr_a;
   logic        valid_a, halted_a;
   logic [15:0] fetch_a, bubble_a;
   logic [31:0] pc_b, pc4_b, instr_b;
   logic        valid_b, halted_b;
   logic [3:0]  fetch_b, bubble_b;

   pipe_if_id #(.CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc4_in(pc4_in),
      .instr_in(instr_in), .stall(stall), .flush(flush), .pc(pc_a),
      .pc4_out(pc4_a), .instr_out(instr_a), .valid_out(valid_a),
      .halted(halted_a), .fetch_cnt(fetch_a), .bubble_cnt(bubble_a)
   );

   pipe_if_id #(.CNT_W(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc4_in(pc4_in),
      .instr_in(instr_in), .stall(stall), .flush(flush), .pc(pc_b),
      .pc4_out(pc4_b), .instr_out(instr_b), .valid_out(valid_b),
      .halted(halted_b), .fetch_cnt(fetch_b), .bubble_cnt(bubble_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_pc, m_pc4, m_instr;
   logic        m_valid, m_halted, m_boot;
   int unsigned m_fetch, m_bubble;
   logic [31:0] prog [64];

   function automatic logic [31:0] sat(input int unsigned n, input int unsigned w);
      int unsigned lim;
      lim = (1 << w) - 1;
      return (n > lim) ? lim : n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("pc",         pc_a,           m_pc);
      chk("pc4",        pc4_a,          m_pc4);
      chk("instr",      instr_a,        m_instr);
      chk("valid",      32'(valid_a),   32'(m_valid));
      chk("halted",     32'(halted_a),  32'(m_halted));
      chk("fetch16",    32'(fetch_a),   sat(m_fetch, 16));
      chk("bubble16",   32'(bubble_a),  sat(m_bubble, 16));
      chk("pc_w4",      pc_b,           m_pc);
      chk("instr_w4",   instr_b,        m_instr);
      chk("valid_w4",   32'(valid_b),   32'(m_valid));
      chk("halted_w4",  32'(halted_b),  32'(m_halted));
      chk("pc4_w4",     pc4_b,          m_pc4);
      chk("fetch4",     32'(fetch_b),   sat(m_fetch, 4));
      chk("bubble4",    32'(bubble_b),  sat(m_bubble, 4));
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_pc4 = 32'h0; m_instr = NOP_W;
      m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
      m_fetch = 0; m_bubble = 0;
   endtask

   task automatic model_clock();
      if (m_boot) begin
         m_boot = 1'b0; m_instr = NOP_W; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (m_halted) begin
      end else if (flush) begin
         m_pc = pc_next; m_instr = NOP_W; m_pc4 = 32'h0; m_valid = 1'b0;
         m_bubble++;
      end else if (m_valid && m_instr == HALT_W) begin
         m_halted = 1'b1; m_instr = NOP_W; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (stall) begin
         m_bubble++;
      end else begin
         m_pc = pc_next; m_instr = instr_in; m_pc4 = pc4_in; m_valid = 1'b1;
         m_fetch++;
      end
   endtask

   task automatic step(input logic st, input logic fl, input logic [31:0] nxt,
                       input logic [31:0] ins);
      stall = st; flush = fl; pc_next = nxt; pc4_in = m_pc + 32'd4; instr_in = ins;
      @(posedge clk);
      model_clock();
      #1;
      check_all();
   endtask

   initial begin
      logic [31:0] frozen_pc;
      logic        st, fl;
      logic [31:0] nxt;

      for (int i = 0; i < 64; i++) prog[i] = $urandom | 32'h1000_0000;

      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      pc_next = '0; pc4_in = '0; instr_in = '0;
      model_reset();
      #12;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // BOOT cycle, then first real fetch
      step(1'b0, 1'b0, m_pc + 32'd4, 32'h2001_0005);
      chk("boot_pc", pc_a, 32'h0);
      chk("boot_valid", 32'(valid_a), 32'h0);
      step(1'b0, 1'b0, m_pc + 32'd4, 32'h2001_0005);
      chk("first_pc", pc_a, 32'h4);
      chk("first_instr", instr_a, 32'h2001_0005);
      chk("first_fetch", 32'(fetch_a), 32'h1);
      step(1'b0, 1'b0, m_pc + 32'd4, 32'h2001_0005);

      // three stall cycles at pc=8
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, m_pc + 32'd4, 32'h2001_0005);
      chk("stall_pc", pc_a, 32'h8);
      chk("stall_bubbles", 32'(bubble_a), 32'h3);
      chk("stall_fetch", 32'(fetch_a), 32'h2);

      // flush wins over stall
      step(1'b1, 1'b1, 32'h0000_0040, 32'h2001_0005);
      chk("flush_pc", pc_a, 32'h40);
      chk("flush_instr", instr_a, 32'h0);
      chk("flush_bubbles", 32'(bubble_a), 32'h4);

      for (int i = 0; i < 60; i++) begin
         st  = ($urandom_range(0, 3) == 0);
         fl  = ($urandom_range(0, 7) == 0);
         nxt = fl ? (32'($urandom_range(0, 63)) << 2) : m_pc + 32'd4;
         step(st, fl, nxt, prog[m_pc[7:2]]);
      end

      // halt word squashed by a same-cycle flush
      step(1'b0, 1'b0, m_pc + 32'd4, HALT_W);
      step(1'b1, 1'b1, 32'h0000_0080, prog[0]);
      chk("halt_flush_halted", 32'(halted_a), 32'h0);
      chk("halt_flush_pc", pc_a, 32'h80);
      chk("halt_flush_valid", 32'(valid_a), 32'h0);

      // real halt, then flush/stall must not disturb it
      step(1'b0, 1'b0, m_pc + 32'd4, HALT_W);
      frozen_pc = m_pc;
      step(1'b1, 1'b0, m_pc + 32'd4, prog[1]);
      chk("halt_halted", 32'(halted_a), 32'h1);
      chk("halt_valid", 32'(valid_a), 32'h0);
      step(1'b0, 1'b1, 32'h0000_0100, prog[2]);
      step(1'b0, 1'b0, 32'h0000_0200, prog[3]);
      chk("halt_frozen_pc", pc_a, frozen_pc);
      chk("halt_still", 32'(halted_a), 32'h1);

      // asynchronous reset mid-cycle
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) step(1'b0, 1'b0, m_pc + 32'd4, prog[m_pc[7:2]]);
      chk("sat_fetch4", 32'(fetch_b), 32'hF);
      chk("fetch16_after", 32'(fetch_a), 32'd19);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
